// File: rtl/dmem_mmio.sv
// dmem_mmio: word-addressed data RAM plus LED/switch/cycle-counter/timer MMIO page, same-cycle read
//   clk, rst               : clock, synchronous active-high reset
//   mem_we, addr, wdata    : core data port (byte address, word access), write commits at next edge
//   rdata                  : combinational read data (RAM, MMIO, or 0 when unmapped)
//   sw_i, led_o            : board switches (two-flop synchronised) and LED register
//   timer_irq              : timer status bit ST
//   dbg_addr, dbg_data     : combinational RAM word inspection port
module dmem_mmio #(
   parameter int DEPTH_WORDS = 1024,
   localparam int AW = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mem_we,
   input  logic [31:0]   addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata,
   input  logic [15:0]   sw_i,
   output logic [15:0]   led_o,
   output logic          timer_irq,
   input  logic [AW-1:0] dbg_addr,
   output logic [31:0]   dbg_data
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   logic [31:0] ram [DEPTH_WORDS];
   logic [15:0] led, sw_q1, sw_q2;
   logic [31:0] cycle, tload, tcount, tcount_n, mmio_rd;
   logic        en, auto_rl, st, en_n, st_n, expire;
   logic        ram_hit, mmio_hit, mmio_we, wr_led, wr_tctrl, wr_tload;
   logic [5:0]  off;
   logic        unused_ok;
   state_t      state, state_n;
   assign unused_ok = ^addr[1:0];
   assign off      = addr[7:2];
   assign ram_hit  = (addr[31:16] == 16'h0) && ({18'd0, addr[15:2]} < 32'(DEPTH_WORDS));
   assign mmio_hit = addr[31:8] == 24'hFFFF00;
   assign mmio_we  = mem_we && mmio_hit;
   assign wr_led   = mmio_we && off == 6'h00;
   assign wr_tctrl = mmio_we && off == 6'h04;
   assign wr_tload = mmio_we && off == 6'h05;
   assign led_o     = led;
   assign timer_irq = st;
   assign dbg_data  = ram[dbg_addr];
   // expiry depends on the current state only, so an EN-clearing write in the
   // expiry cycle still sets ST and reloads/clears the count
   always_comb begin
      expire   = state == RUN && tcount == 32'd1;
      tcount_n = wr_tload ? wdata :
                 expire ? (auto_rl ? tload : 32'd0) :
                 state == RUN ? tcount - 32'd1 : tcount;
      en_n     = wr_tctrl ? wdata[0] : en;
      st_n     = expire | (st & ~(wr_tctrl & wdata[2]));
      state_n  = !en_n ? IDLE : tcount_n != 32'd0 ? RUN : DONE;
   end
   always_comb begin
      mmio_rd = 32'd0;
      case (off)
         6'h00: mmio_rd = {16'd0, led};
         6'h01: mmio_rd = {16'd0, sw_q2};
         6'h02: mmio_rd = cycle;
         6'h04: mmio_rd = {29'd0, st, auto_rl, en};
         6'h05: mmio_rd = tload;
         6'h06: mmio_rd = tcount;
         default: mmio_rd = 32'd0;
      endcase
      rdata = ram_hit ? ram[addr[AW+1:2]] : mmio_hit ? mmio_rd : 32'd0;
   end
   always_ff @(posedge clk)
      if (mem_we && ram_hit) ram[addr[AW+1:2]] <= wdata;
   always_ff @(posedge clk) begin
      if (rst) begin
         led     <= '0;
         sw_q1   <= '0;
         sw_q2   <= '0;
         cycle   <= '0;
         tload   <= '0;
         tcount  <= '0;
         en      <= 1'b0;
         auto_rl <= 1'b0;
         st      <= 1'b0;
         state   <= IDLE;
      end else begin
         if (wr_led) led <= wdata[15:0];
         sw_q1   <= sw_i;
         sw_q2   <= sw_q1;
         cycle   <= cycle + 32'd1;
         if (wr_tload) tload <= wdata;
         if (wr_tctrl) auto_rl <= wdata[1];
         tcount  <= tcount_n;
         en      <= en_n;
         st      <= st_n;
         state   <= state_n;
      end
   end
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed scoreboard bench for dmem_mmio
module tb_dmem_mmio;
   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } item_t;
   logic        clk = 1'b0, rst = 1'b1, mem_we = 1'b0;
   logic [31:0] addr = '0, wdata = '0, rdata, act;
   logic [15:0] sw_i = '0, led_o;
   logic        timer_irq;
   logic [9:0]  dbg_addr = '0;
   logic [31:0] dbg_data;
   item_t       sb[$];
   item_t       it;
   int          checks = 0, errors = 0;
   localparam logic [31:0] LED = 32'hFFFF0000, SW = 32'hFFFF0004, CYC = 32'hFFFF0008,
                           TCTRL = 32'hFFFF0010, TLOAD = 32'hFFFF0014, TCNT = 32'hFFFF0018;
   dmem_mmio #(.DEPTH_WORDS(1024)) dut (
      .clk(clk), .rst(rst), .mem_we(mem_we), .addr(addr), .wdata(wdata), .rdata(rdata),
      .sw_i(sw_i), .led_o(led_o), .timer_irq(timer_irq), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         it  = sb.pop_front();
         act = it.sel == 0 ? rdata : it.sel == 1 ? {16'd0, led_o} : it.sel == 2 ? {31'd0, timer_irq} : dbg_data;
         checks++;
         if (act !== it.exp) begin
            errors++;
            $display("FAIL %s: got %08h want %08h", it.name, act, it.exp);
         end
      end
   end
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string n, input int s, input logic [31:0] e);
      sb.push_back('{n, s, e});
   endtask
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      mem_we = 1'b1; addr = a; wdata = d;
   endtask
   task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
      mem_we = 1'b0; addr = a; wdata = '0;
      chk(n, 0, e);
   endtask
   initial begin
      step;
      rd(CYC, 0, "rst_cycle"); chk("rst_led", 1, 0); chk("rst_irq", 2, 0); rst = 1'b0; step;
      rd(CYC, 1, "cycle_inc"); step;
      rd(CYC, 2, "cycle_inc2"); step;
      wr(32'h10, 32'hDEADBEEF); step;
      rd(32'h13, 32'hDEADBEEF, "ram_rd"); dbg_addr = 10'd4; chk("ram_dbg", 3, 32'hDEADBEEF); step;
      wr(32'h10, 32'h11112222); chk("ram_rdw_old", 0, 32'hDEADBEEF); step;
      rd(32'h10, 32'h11112222, "ram_new"); step;
      rd(32'h00010000, 0, "unmapped_hi"); step;
      wr(32'h00010010, 32'hBAD0BAD0); step;
      wr(32'h0, 32'hA5A5A5A5); chk("unmapped_wr_drop", 3, 32'h11112222); step;
      wr(32'h1000, 32'h55); step;
      rd(32'h1000, 0, "ram_oob"); dbg_addr = 10'd0; chk("ram_oob_alias", 3, 32'hA5A5A5A5); step;
      wr(32'hFFC, 32'h77); step;
      rd(32'hFFC, 32'h77, "ram_last"); step;
      wr(LED, 32'h1234ABCD); chk("led_pre", 1, 0); step;
      rd(LED, 32'h0000ABCD, "led_rd"); chk("led_o", 1, 32'hABCD); step;
      sw_i = 16'h00F0; rd(SW, 0, "sw_lat0"); step;
      rd(SW, 0, "sw_lat1"); step;
      rd(SW, 32'hF0, "sw"); step;
      wr(TCNT, 9); step;
      rd(TCNT, 0, "ro_drop"); step;
      rd(32'hFFFF000C, 0, "mmio_hole"); step;
      rd(32'hFFFE0000, 0, "unmapped_mmio"); step;
      wr(TLOAD, 3); step;
      wr(TCTRL, 1); chk("os_irq0", 2, 0); step;
      rd(TCNT, 3, "os_c3"); step;
      rd(TCNT, 2, "os_c2"); step;
      rd(TCNT, 1, "os_c1"); chk("os_irq_pre", 2, 0); step;
      rd(TCNT, 0, "os_c0"); chk("os_irq_rise", 2, 1); step;
      rd(TCTRL, 5, "os_tctrl"); chk("os_irq_hold", 2, 1); step;
      wr(TCTRL, 5); chk("w1c_cycle", 2, 1); step;
      rd(TCTRL, 1, "w1c_en_kept"); chk("w1c_irq", 2, 0); step;
      wr(TLOAD, 2); step;
      rd(TCNT, 2, "done_run_c2"); step;
      rd(TCNT, 1, "done_run_c1"); step;
      rd(TCNT, 0, "done_run_c0"); chk("done_run_irq", 2, 1); step;
      wr(TCTRL, 4); step;
      rd(TCTRL, 0, "off_tctrl"); chk("off_irq", 2, 0); step;
      wr(TLOAD, 2); step;
      wr(TCTRL, 3); step;
      rd(TCNT, 2, "ar_c2a"); step;
      rd(TCNT, 1, "ar_c1a"); chk("ar_irq0", 2, 0); step;
      rd(TCNT, 2, "ar_c2b"); chk("ar_st", 2, 1); step;
      wr(TCTRL, 7); chk("ar_exp_irq", 2, 1); step;
      rd(TCTRL, 7, "st_set_wins"); step;
      rd(TCNT, 1, "ar_c1b"); step;
      wr(TCTRL, 7); step;
      rd(TCTRL, 3, "w1c_clear"); chk("w1c_clear_irq", 2, 0); step;
      rd(TCTRL, 7, "ar_st_again"); step;
      wr(TLOAD, 9); step;
      rd(TCNT, 9, "load_wins"); step;
      rd(TCNT, 8, "load_dec"); step;
      wr(TCTRL, 7); step;
      wr(TLOAD, 1); step;
      wr(TCTRL, 2); chk("en_off_exp_pre", 2, 0); step;
      rd(TCNT, 1, "en_off_reload"); chk("en_off_st", 2, 1); step;
      rd(TCTRL, 6, "en_off_tctrl"); step;
      rd(TCNT, 1, "idle_hold"); step;
      wr(TLOAD, 5); step;
      wr(TCTRL, 5); step;
      rd(TCNT, 5, "pre_rst_c5"); step;
      rst = 1'b1; rd(TCNT, 4, "pre_rst_c4"); step;
      rst = 1'b0; rd(TCNT, 0, "rst_tcount"); chk("rst_irq2", 2, 0); step;
      rd(CYC, 1, "rst_cycle2"); step;
      rd(TCTRL, 0, "rst_tctrl"); step;
      rd(TLOAD, 0, "rst_tload"); step;
      rd(LED, 0, "rst_led_rd"); chk("rst_led_o", 1, 0); step;
      rd(32'h10, 32'h11112222, "rst_ram"); dbg_addr = 10'd4; chk("rst_ram_dbg", 3, 32'h11112222); step;
      rd(TCNT, 0, "rst_timer_idle"); step;
      step;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end
endmodule
